// File: rtl/fp_sqrt_pkg.sv
// Shared types and constants for the floating-point square root datapath.
package fp_sqrt_pkg;

  localparam int unsigned EXP_W_DEF = 8;
  localparam int unsigned MAN_W_DEF = 23;
  localparam int unsigned MAX_W     = 64;

  typedef struct packed {
    logic nan;
    logic snan;
    logic zero;
    logic inf;
    logic neg;
    logic sub;
  } fp_class_t;

  // Result-source selection, listed in override priority order (highest first).
  typedef enum logic [2:0] {
    SEL_NAN     = 3'd0,
    SEL_ZERO    = 3'd1,
    SEL_INVALID = 3'd2,
    SEL_INF     = 3'd3,
    SEL_CORE    = 3'd4
  } sel_t;

  function automatic logic [MAX_W-1:0] legacy_nan(input int unsigned w);
    return {MAX_W{1'b1}} >> (MAX_W - w);
  endfunction

  function automatic logic [MAX_W-1:0] canon_qnan(input int unsigned exp_w,
                                                  input int unsigned man_w);
    logic [MAX_W-1:0] exp_ones;
    exp_ones = {MAX_W{1'b1}} >> (MAX_W - exp_w);
    return (exp_ones << man_w) | (MAX_W'(1) << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational operand classifier: decodes an IEEE-754 word into class bits.
module fp_classify
  import fp_sqrt_pkg::*;
#(
  parameter int unsigned EXP_W = EXP_W_DEF,
  parameter int unsigned MAN_W = MAN_W_DEF
) (
  input  logic [EXP_W+MAN_W:0] op,
  output fp_class_t            cls_c
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] frac;
  logic             exp_ones;
  logic             exp_zero;
  logic             frac_nz;

  assign exp_f    = op[EXP_W+MAN_W-1:MAN_W];
  assign frac     = op[MAN_W-1:0];
  assign exp_ones = &exp_f;
  assign exp_zero = ~|exp_f;
  assign frac_nz  = |frac;

  assign cls_c.nan  = exp_ones & frac_nz;
  assign cls_c.snan = exp_ones & frac_nz & ~frac[MAN_W-1];
  assign cls_c.zero = exp_zero & ~frac_nz;
  assign cls_c.inf  = exp_ones & ~frac_nz;
  assign cls_c.neg  = op[EXP_W+MAN_W];
  assign cls_c.sub  = exp_zero & frac_nz;

endmodule

// File: rtl/fp_sqrt_special_out.sv
// Sqrt output stage: pairs core results with operands and applies special-case overrides.
// Optional macro FP_SQRT_DAZ_EN flushes subnormal operands to signed zero.
module fp_sqrt_special_out
  import fp_sqrt_pkg::*;
#(
  parameter int unsigned EXP_W        = EXP_W_DEF,
  parameter int unsigned MAN_W        = MAN_W_DEF,
  parameter int unsigned NAN_ALL_ONES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   op_i,
  input  logic [EXP_W+MAN_W:0]   core_i,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   data_o,
  output logic                   special_o,
  output logic                   flag_invalid,
  input  logic                   flag_clr,
  output logic [CNT_W-1:0]       spec_cnt
);

  localparam int unsigned W = 1 + EXP_W + MAN_W;

  localparam logic [W-1:0] INV_WORD  = (NAN_ALL_ONES != 0) ? W'(legacy_nan(W))
                                                           : W'(canon_qnan(EXP_W, MAN_W));
  localparam logic [W-1:0] POS_INF   = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  localparam logic [W-1:0] QUIET_BIT = W'(1) << (MAN_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  fp_class_t      in_cls_c;
  fp_class_t      s1_cls;
  logic [W-1:0]   s1_op;
  logic [W-1:0]   s1_core;
  logic           s1_valid;
  logic           out_invalid;

  logic           s1_en;
  logic           s2_en;
  logic           out_xfer;
  logic           zero_like;
  sel_t           sel;
  logic [W-1:0]   nxt_data;
  logic           nxt_special;
  logic           nxt_invalid;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_classify (
    .op    (op_i),
    .cls_c (in_cls_c)
  );

  assign s2_en    = !out_valid | out_ready;
  assign s1_en    = !s1_valid | s2_en;
  assign in_ready = s1_en;
  assign out_xfer = out_valid & out_ready;

`ifdef FP_SQRT_DAZ_EN
  assign zero_like = s1_cls.zero | s1_cls.sub;
`else
  assign zero_like = s1_cls.zero & ~s1_cls.sub;
`endif

  // Override selection and result formation for the stage-1 pair.
  always_comb begin
    sel         = SEL_CORE;
    nxt_data    = s1_core;
    nxt_special = 1'b0;
    if (s1_cls.nan)       sel = SEL_NAN;
    else if (zero_like)   sel = SEL_ZERO;
    else if (s1_cls.neg)  sel = SEL_INVALID;
    else if (s1_cls.inf)  sel = SEL_INF;

    case (sel)
      SEL_NAN:     begin nxt_data = s1_op | QUIET_BIT;                  nxt_special = 1'b1; end
      SEL_ZERO:    begin nxt_data = {s1_op[W-1], {(W-1){1'b0}}};        nxt_special = 1'b1; end
      SEL_INVALID: begin nxt_data = INV_WORD;                           nxt_special = 1'b1; end
      SEL_INF:     begin nxt_data = POS_INF;                            nxt_special = 1'b1; end
      default:     begin nxt_data = s1_core;                            nxt_special = 1'b0; end
    endcase
    // Quiet NaN operands propagate silently; only sNaN and negative non-zero raise invalid.
    nxt_invalid = s1_cls.snan | (sel == SEL_INVALID);
  end

  // Stage-1 payload: not reset, qualified by s1_valid.
  always_ff @(posedge clk) begin
    if (in_valid && s1_en) begin
      s1_op   <= op_i;
      s1_core <= core_i;
      s1_cls  <= in_cls_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid     <= 1'b0;
      out_valid    <= 1'b0;
      data_o       <= '0;
      special_o    <= 1'b0;
      out_invalid  <= 1'b0;
      flag_invalid <= 1'b0;
      spec_cnt     <= '0;
    end else begin
      if (s1_en) s1_valid <= in_valid;

      if (s2_en) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          data_o      <= nxt_data;
          special_o   <= nxt_special;
          out_invalid <= nxt_invalid;
        end
      end

      if (flag_clr)                      flag_invalid <= 1'b0;
      else if (out_xfer && out_invalid)  flag_invalid <= 1'b1;

      if (flag_clr)                                          spec_cnt <= '0;
      else if (out_xfer && special_o && spec_cnt != CNT_MAX) spec_cnt <= spec_cnt + CNT_W'(1);
    end
  end

endmodule
